// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_pkg
//  Description : Shared types and defaults for the program-counter sequencer:
//                next-PC source encoding and default reset/trap vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Source selected for the next PC value.
    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_RET    = 3'd3,
        SRC_TRAP   = 3'd4,
        SRC_HOLD   = 3'd5
    } next_src_e;

    localparam logic [31:0] c_DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] c_DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. A push while full overwrites
//                the oldest entry. Storage is not reset, only pointer/count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_data_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]    mem_q [RAS_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [c_PTR_W-1:0] top_idx;
    logic [c_PTR_W-1:0] wr_idx;
    logic               do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == c_CNT_W'(RAS_DEPTH));
    assign top_idx    = wr_ptr_q - c_PTR_W'(1);
    assign top_data_o = mem_q[top_idx];
    assign do_pop     = pop_i && !empty_o;
    // A simultaneous pop+push replaces the top entry in place.
    assign wr_idx     = do_pop ? top_idx : wr_ptr_q;

    // Next pointer/count; pointer wraps naturally since depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push_i && do_pop) begin
            wr_ptr_d = wr_ptr_q;
            cnt_d    = cnt_q;
        end else if (push_i) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            cnt_d    = full_o ? cnt_q : cnt_q + c_CNT_W'(1);
        end else if (do_pop) begin
            wr_ptr_d = top_idx;
            cnt_d    = cnt_q - c_CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage, intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push_i && !rst) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Architectural PC register with prioritised next-PC selection
//                (trap, stall, return, jump, branch, sequential), a return-
//                address stack and misaligned-target redirection.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(c_DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(c_DEFAULT_TRAP_VECTOR),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            trap_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_seq_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            misaligned_o,
    output logic            ras_underflow_o
);

    // Mask of address bits that must be zero; all-zero when INSTR_BYTES is 1,
    // which disables the alignment check.
    localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    logic            underflow_q, underflow_d;

    next_src_e       src_sel;
    logic [XLEN-1:0] redirect_tgt;
    logic            check_align;
    logic            ras_push, ras_pop;
    logic [XLEN-1:0] ras_top;

    assign pc_seq_o        = pc_q + XLEN'(INSTR_BYTES);
    assign pc_o            = pc_q;
    assign misaligned_o    = misaligned_q;
    assign ras_underflow_o = underflow_q;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_seq_o),
        .top_data_o  (ras_top),
        .empty_o     (ras_empty_o),
        .full_o      (ras_full_o)
    );

    // Priority decode of the next-PC source plus RAS side effects.
    always_comb begin
        src_sel      = SRC_SEQ;
        redirect_tgt = pc_seq_o;
        check_align  = 1'b0;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        underflow_d  = 1'b0;
        if (trap_i) begin
            src_sel = SRC_TRAP;
        end else if (stall_i) begin
            src_sel = SRC_HOLD;
        end else if (ret_i) begin
            if (!ras_empty_o) begin
                src_sel      = SRC_RET;
                redirect_tgt = ras_top;
                check_align  = 1'b1;
                ras_pop      = 1'b1;
            end else begin
                underflow_d  = 1'b1;
            end
        end else if (jump_i) begin
            src_sel      = SRC_JUMP;
            redirect_tgt = jump_target_i;
            check_align  = 1'b1;
            ras_push     = call_i;
        end else if (branch_taken_i) begin
            src_sel      = SRC_BRANCH;
            redirect_tgt = branch_target_i;
            check_align  = 1'b1;
        end
    end

    // Next-PC mux; a misaligned redirect diverts to the trap vector.
    always_comb begin
        misaligned_d = check_align && ((redirect_tgt & c_ALIGN_MASK) != '0);
        case (src_sel)
            SRC_TRAP: pc_d = TRAP_VECTOR;
            SRC_HOLD: pc_d = pc_q;
            default:  pc_d = misaligned_d ? TRAP_VECTOR : redirect_tgt;
        endcase
    end

    // PC and pulse-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            underflow_q  <= underflow_d;
        end
    end

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer with a queue-based
//                reference model and hand-computed directed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] TV    = 32'h0000_0100;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall, trap, br, jmp, call, ret;
    logic [31:0] br_tgt, jmp_tgt;
    logic [31:0] pc, pc_seq;
    logic        ras_empty, ras_full, mis, uf;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(
        .XLEN         (32),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .trap_i          (trap),
        .branch_taken_i  (br),
        .branch_target_i (br_tgt),
        .jump_i          (jmp),
        .jump_target_i   (jmp_tgt),
        .call_i          (call),
        .ret_i           (ret),
        .pc_o            (pc),
        .pc_seq_o        (pc_seq),
        .ras_empty_o     (ras_empty),
        .ras_full_o      (ras_full),
        .misaligned_o    (mis),
        .ras_underflow_o (uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic        m_mis, m_uf, m_valid;
    logic [31:0] m_ras[$];

    initial begin
        m_valid = 1'b0;
        m_pc    = '0;
        m_mis   = 1'b0;
        m_uf    = 1'b0;
    end

    function automatic void m_redirect(input logic [31:0] t);
        if (t % 4 != 0) begin
            m_pc  = TV;
            m_mis = 1'b1;
        end else begin
            m_pc = t;
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] t;
        m_mis = 1'b0;
        m_uf  = 1'b0;
        if (rst) begin
            m_pc = RV;
            m_ras.delete();
            m_valid = 1'b1;
        end else if (trap) begin
            m_pc = TV;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                t = m_ras.pop_back();
                m_redirect(t);
            end else begin
                m_pc = m_pc + 32'd4;
                m_uf = 1'b1;
            end
        end else if (jmp) begin
            if (call) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_redirect(jmp_tgt);
        end else if (br) begin
            m_redirect(br_tgt);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    end

    // Compare DUT against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc",        pc,                  m_pc);
            chk("pc_seq",    pc_seq,              m_pc + 32'd4);
            chk("ras_empty", {31'd0, ras_empty},  {31'd0, m_ras.size() == 0});
            chk("ras_full",  {31'd0, ras_full},   {31'd0, m_ras.size() == DEPTH});
            chk("misaligned",{31'd0, mis},        {31'd0, m_mis});
            chk("underflow", {31'd0, uf},         {31'd0, m_uf});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        stall = 0; trap = 0; br = 0; jmp = 0; call = 0; ret = 0;
        br_tgt = '0; jmp_tgt = '0;
    endtask

    // Apply current inputs for one edge, return just after the next negedge.
    task automatic step();
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_jump(input logic [31:0] t, input logic c);
        jmp = 1; jmp_tgt = t; call = c;
        step();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        chk("reset_pc", pc, 32'h0);
        chk("reset_empty", {31'd0, ras_empty}, 32'd1);
        rst = 1'b0;

        // sequential run
        step(); step(); step();
        chk("seq_pc_c", pc, 32'hC);
        step();
        chk("seq_pc_10", pc, 32'h10);

        // call then return
        do_jump(32'h200, 1'b1);
        chk("call_pc", pc, 32'h200);
        step();
        chk("after_call_pc", pc, 32'h204);
        ret = 1; step();
        chk("ret_pc", pc, 32'h14);
        chk("ret_empty", {31'd0, ras_empty}, 32'd1);

        // five nested calls overflow a 4-deep stack
        do_jump(32'h1000, 1'b1);
        do_jump(32'h2000, 1'b1);
        do_jump(32'h3000, 1'b1);
        do_jump(32'h4000, 1'b1);
        chk("ras_full4", {31'd0, ras_full}, 32'd1);
        do_jump(32'h5000, 1'b1);
        ret = 1; step(); chk("ret_E", pc, 32'h4004);
        ret = 1; step(); chk("ret_D", pc, 32'h3004);
        ret = 1; step(); chk("ret_C", pc, 32'h2004);
        ret = 1; step(); chk("ret_B", pc, 32'h1004);
        ret = 1; step();
        chk("ret_underflow_pc", pc, 32'h1008);
        chk("ret_underflow_flag", {31'd0, uf}, 32'd1);
        step();
        chk("underflow_clears", {31'd0, uf}, 32'd0);

        // misaligned branch
        br = 1; br_tgt = 32'h102; step();
        chk("mis_branch_pc", pc, 32'h100);
        chk("mis_branch_flag", {31'd0, mis}, 32'd1);
        step();
        chk("mis_clears", {31'd0, mis}, 32'd0);
        chk("mis_next_pc", pc, 32'h104);

        // stall with branch pending, then trap during stall
        do_jump(32'h40, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stall = 1; br = 1; br_tgt = 32'h800; step();
        end
        chk("stall_hold", pc, 32'h40);
        stall = 1; trap = 1; step();
        chk("trap_in_stall", pc, 32'h100);

        // misaligned jump+call still pushes; ret beats a simultaneous jump
        do_jump(32'h203, 1'b1);
        chk("mis_jump_pc", pc, 32'h100);
        chk("mis_jump_empty", {31'd0, ras_empty}, 32'd0);
        ret = 1; jmp = 1; jmp_tgt = 32'h700; call = 1; step();
        chk("ret_over_jump", pc, 32'h104);

        // trap leaves the stack intact
        do_jump(32'h300, 1'b1);
        trap = 1; step();
        chk("trap_keeps_ras", {31'd0, ras_empty}, 32'd0);

        // reset with jump+call present
        rst = 1; jmp = 1; jmp_tgt = 32'h500; call = 1; step();
        chk("rst_mid_pc", pc, 32'h0);
        chk("rst_mid_empty", {31'd0, ras_empty}, 32'd1);
        rst = 0;

        // wrap at top of address space
        do_jump(32'hFFFF_FFFC, 1'b0);
        chk("wrap_seq", pc_seq, 32'h0);
        step();
        chk("wrap_pc", pc, 32'h0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit; next generation of the plain PC+4 incrementer. It holds the architectural PC register and selects the next PC from several sources: sequential, branch, jump, return and trap. It includes a small return-address stack (RAS) and detects misaligned redirect targets. It sits at the front of the fetch stage, feeding instruction-memory address and the link value to writeback.

Parameters:
XLEN, 32, PC/address width in bits
INSTR_BYTES, 4, sequential increment; power of two, at least 1
RESET_VECTOR, 0, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect
RAS_DEPTH, 4, return-address stack entries; power of two, at least 2

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC (pipeline freeze)
trap  in  1  redirect to TRAP_VECTOR
branch_taken  in  1  redirect to branch_target
branch_target  in  XLEN  branch destination
jump  in  1  redirect to jump_target
jump_target  in  XLEN  jump destination
call  in  1  qualifies jump: push link on RAS
ret  in  1  redirect to popped RAS entry
pc  out  XLEN  current PC (registered)
pc_seq  out  XLEN  pc + INSTR_BYTES (combinational; link value)
ras_empty  out  1  RAS holds 0 valid entries
ras_full  out  1  RAS holds RAS_DEPTH valid entries
misaligned  out  1  one-cycle pulse: last redirect target was misaligned
ras_underflow  out  1  one-cycle pulse: ret issued with empty RAS

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_VECTOR, RAS count=0, top pointer=0, misaligned=0, ras_underflow=0. ras_empty=1, ras_full=0. rst overrides all other inputs.
- pc_seq = pc + INSTR_BYTES, truncated modulo 2^XLEN. 0xFFFFFFFC+4 wraps to 0 with no flag.
- Next-PC priority, one update per edge, 1-cycle latency:
  1. trap
  2. stall (hold)
  3. ret
  4. jump
  5. branch_taken
  6. sequential
- Trap overrides stall. A trap during stall still redirects. Trap does not modify the RAS.
- stall=1 (no trap): pc, RAS and flags hold. Pulse outputs clear to 0.
- ret: if RAS is non-empty, pc takes the top entry, then pop (count-1). If RAS is empty, pc=pc_seq and ras_underflow=1 for one cycle.
- jump: pc=jump_target. If call=1, push pc_seq. If RAS is full, the push overwrites the oldest entry (circular): count stays RAS_DEPTH and the top pointer advances.
- call without jump is ignored. ret together with jump: ret wins, jump and call are ignored.
- branch_taken: pc=branch_target.
- Alignment: a target is misaligned if its low log2(INSTR_BYTES) bits are non-zero. This applies to branch, jump and popped RAS targets.
  - On a misaligned target, pc=TRAP_VECTOR and misaligned=1 for one cycle.
  - A RAS pop or push that accompanied the redirect still happens.
  - Alignment is not checked when INSTR_BYTES=1.
- Pulses (misaligned, ras_underflow) are registered and last exactly one cycle unless the condition repeats.
- RAS storage is not cleared by reset; only the pointers and count are reset.

Decomposition:
- Shared package holds:
  - the next-PC source encoding (SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_RET, SRC_TRAP, SRC_HOLD)
  - default RESET_VECTOR and TRAP_VECTOR constants.
- One natural sub-module: ras_stack.
  - Parameters: XLEN, RAS_DEPTH.
  - Ports: push, pop, push_data, top_data, empty, full.
  - Behaviour: circular overwrite on full.
- The PC register and priority mux stay in pc_sequencer.

Test Plan:
- Reset release, 3 idle cycles: pc goes 0x0 → 0x4 → 0x8 → 0xC. pc_seq is always pc+4.
- At pc=0x10, assert jump+call with target 0x200, then ret two cycles later: pc goes 0x200 → 0x204 → 0x14. ras_empty returns to 1.
- Perform 5 calls with RAS_DEPTH=4 (links A,B,C,D,E), then 5 rets: returns are E,D,C,B. The 5th ret gives pc_seq and ras_underflow=1.
- branch_taken with target 0x102: pc=0x100 (TRAP_VECTOR) and misaligned=1 for exactly one cycle.
- stall held 3 cycles at pc=0x40 with branch_taken=1: pc stays 0x40. Trap during stall: pc=0x100 on the next edge.
- rst asserted mid-sequence together with jump+call: pc=0x0 and ras_empty=1 on the next edge. Then pc=0xFFFFFFFC sequential → pc=0x0 (wrap).
